// File: rtl/armleocpu_regfile_mp_if.sv
// rtl/armleocpu_regfile_mp_if.sv - pipeline-side bus of the multi-port register file
//
// Purpose: bundles the status, clear, read and write signals of
//          armleocpu_regfile_mp so the core and the file share one port.
// Signals:
//   ready      file initialised, reads and writes are honoured
//   clear_req  one-cycle pulse in READY restarts the clear sequence
//   rs_addr    READ_PORTS packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rs_rdata   READ_PORTS packed read data,      port i at [i*XLEN +: XLEN]
//   rd0_*      write port 0 (enable, address, data)
//   rd1_*      write port 1 (enable, address, data), wins over port 0
// Modports: master = pipeline, slave = register file.

interface armleocpu_regfile_mp_if #(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 5,
   parameter int READ_PORTS = 2
);
   logic                         ready;
   logic                         clear_req;
   logic [READ_PORTS*ADDR_W-1:0] rs_addr;
   logic [READ_PORTS*XLEN-1:0]   rs_rdata;
   logic                         rd0_write;
   logic [ADDR_W-1:0]            rd0_addr;
   logic [XLEN-1:0]              rd0_wdata;
   logic                         rd1_write;
   logic [ADDR_W-1:0]            rd1_addr;
   logic [XLEN-1:0]              rd1_wdata;

   modport master (
      input  ready, rs_rdata,
      output clear_req, rs_addr,
      output rd0_write, rd0_addr, rd0_wdata,
      output rd1_write, rd1_addr, rd1_wdata
   );

   modport slave (
      output ready, rs_rdata,
      input  clear_req, rs_addr,
      input  rd0_write, rd0_addr, rd0_wdata,
      input  rd1_write, rd1_addr, rd1_wdata
   );
endinterface

// File: rtl/armleocpu_regfile_mp.sv
// rtl/armleocpu_regfile_mp.sv - READ_PORTS-read / 2-write integer register file with clear sequencer
//
// Purpose: integer register file for the ArmleoCPU core. Reads are
//          combinational; both write ports update on the rising clock edge.
//          After reset, or on clear_req, a sequencer zeroes one entry per
//          cycle; ready stays low until every entry has been cleared.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-high reset (forces CLEAR, clr_idx = 0)
//   bus   armleocpu_regfile_mp_if.slave (ready, clear_req, rs_*, rd0_*, rd1_*)
// Parameters: XLEN, ADDR_W (DEPTH = 2**ADDR_W), READ_PORTS (1..4), ZERO_REG.
// Configuration: define ARMLEOCPU_REGFILE_BYPASS_EN to forward same-cycle
//                write data to matching reads (port 1 over port 0).

module armleocpu_regfile_mp #(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 5,
   parameter int READ_PORTS = 2,
   parameter int ZERO_REG   = 1
) (
   input logic                    clk,
   input logic                    rst,
   armleocpu_regfile_mp_if.slave  bus
);

   localparam int                DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

   if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_bad_read_ports
      $error("armleocpu_regfile_mp: READ_PORTS must be in 1..4");
   end

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] clr_idx, clr_idx_n;
   logic [XLEN-1:0]   mem [DEPTH];

   logic              wr0_en, wr1_en;
   logic [ADDR_W-1:0] rd_a;
   logic [XLEN-1:0]   rd_v;
   logic [READ_PORTS*XLEN-1:0] rdata_all;

   // A write is effective only in READY, not in the cycle a clear is
   // requested, and never to the hard-wired zero entry.
   always_comb begin
      wr0_en = (state == READY) && !bus.clear_req && bus.rd0_write &&
               !((ZERO_REG != 0) && (bus.rd0_addr == '0));
      wr1_en = (state == READY) && !bus.clear_req && bus.rd1_write &&
               !((ZERO_REG != 0) && (bus.rd1_addr == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_n;
         clr_idx <= clr_idx_n;
      end
   end

   always_comb begin
      state_n   = state;
      clr_idx_n = clr_idx;
      case (state)
         CLEAR: begin
            // Counter wraps back to 0 on the last entry, so READY starts at 0.
            clr_idx_n = clr_idx + ONE;
            if (clr_idx == LAST)
               state_n = READY;
         end
         READY: begin
            if (bus.clear_req) begin
               state_n   = CLEAR;
               clr_idx_n = '0;
            end
         end
         default: begin
            state_n   = CLEAR;
            clr_idx_n = '0;
         end
      endcase
   end

   // Storage has no reset; the sequencer zeroes it. Port 1 is assigned last
   // so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_idx] <= '0;
      end else begin
         if (wr0_en)
            mem[bus.rd0_addr] <= bus.rd0_wdata;
         if (wr1_en)
            mem[bus.rd1_addr] <= bus.rd1_wdata;
      end
   end

   always_comb begin
      rdata_all = '0;
      rd_a      = '0;
      rd_v      = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         rd_a = bus.rs_addr[p*ADDR_W +: ADDR_W];
         rd_v = mem[rd_a];
`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
         // wr*_en already excludes CLEAR, clear_req and the zero entry.
         if (wr1_en && (bus.rd1_addr == rd_a))
            rd_v = bus.rd1_wdata;
         else if (wr0_en && (bus.rd0_addr == rd_a))
            rd_v = bus.rd0_wdata;
`endif
         if (state != READY)
            rd_v = '0;
         if ((ZERO_REG != 0) && (rd_a == '0))
            rd_v = '0;
         rdata_all[p*XLEN +: XLEN] = rd_v;
      end
   end

   assign bus.rs_rdata = rdata_all;
   assign bus.ready    = (state == READY);

endmodule
